// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode helpers for the N-bit sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_nbit_comb.sv
// Single-cycle datapath: logic ops, WIDTH+1-bit adder, signed/unsigned compare and flags.
module alu_nbit_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_i,
    input  logic [3:0]       operacion_i,
    output logic [WIDTH-1:0] resultado_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             err_o
);

    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             add_carry;
    logic             add_ovf;

    // Compares always subtract; ADD subtracts only when asked to.
    assign sub_mode  = ((operacion_i == OP_ADD) && invert_i) ||
                       (operacion_i == OP_SLT) || (operacion_i == OP_SLTU);
    assign b_eff     = sub_mode ? ~b_i : b_i;
    assign sum_ext   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign add_carry = sum_ext[WIDTH];
    assign add_ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum_ext[WIDTH-1] != a_i[WIDTH-1]);

    always_comb begin
        resultado_o = '0;
        carry_o     = 1'b0;
        overflow_o  = 1'b0;
        err_o       = 1'b0;
        case (operacion_i)
            OP_AND:  resultado_o = a_i & b_i;
            OP_OR:   resultado_o = a_i | b_i;
            OP_XOR:  resultado_o = a_i ^ b_i;
            OP_ADD: begin
                resultado_o = sum_ext[WIDTH-1:0];
                carry_o     = add_carry;
                overflow_o  = add_ovf;
            end
            OP_SLT:  resultado_o = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_ovf};
            OP_SLTU: resultado_o = {{(WIDTH-1){1'b0}}, ~add_carry};
            // Shifts are iterated by the sequencer; nothing to do here.
            OP_SRL, OP_SLL, OP_SRA: resultado_o = '0;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// N-bit ALU with valid/ready handshakes; shifts iterate one bit per cycle.
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             invert_i,
    input  logic [3:0]       operacion_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] resultado_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             err_o
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_carry;
    logic               comb_ovf;
    logic               comb_err;
    logic [WIDTH-1:0]   shift_nxt;
    logic [SHAMT_W-1:0] shamt;

    alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i         (a_i),
        .b_i         (b_i),
        .invert_i    (invert_i),
        .operacion_i (operacion_i),
        .resultado_o (comb_res),
        .carry_o     (comb_carry),
        .overflow_o  (comb_ovf),
        .err_o       (comb_err)
    );

    assign shamt = b_i[SHAMT_W-1:0];

    always_comb begin
        case (op_q)
            OP_SLL:  shift_nxt = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_nxt = {1'b0, work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d    = operacion_i;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    if (is_shift(operacion_i)) begin
                        if (shamt == '0) begin
                            res_d   = a_i;
                            zero_d  = (a_i == '0);
                            state_d = DONE;
                        end else begin
                            work_d  = a_i;
                            cnt_d   = shamt;
                            state_d = SHIFT;
                        end
                    end else begin
                        res_d   = comb_res;
                        zero_d  = (comb_res == '0);
                        carry_d = comb_carry;
                        ovf_d   = comb_ovf;
                        err_d   = comb_err;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shift_nxt;
                cnt_d  = cnt_q - SHAMT_W'(1);
                // Final step publishes straight into the result so latency is 1+shamt.
                if (cnt_q == SHAMT_W'(1)) begin
                    res_d   = shift_nxt;
                    zero_d  = (shift_nxt == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = (state_q == DONE);
    assign resultado_o = res_q;
    assign zero_o      = zero_q;
    assign carry_o     = carry_q;
    assign overflow_o  = ovf_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed bench for alu_nbit_seq at WIDTH=8 with an arithmetic reference model.
module tb_alu_nbit_seq;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         invert_i = 1'b0;
    logic [3:0]   operacion_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] resultado_o;
    logic         zero_o, carry_o, overflow_o, err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z, c, v, e;
        int           lat;
    } exp_t;

    exp_t exp_cur;
    logic exp_armed = 1'b0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .invert_i(invert_i), .operacion_i(operacion_i),
        .valid_o(valid_o), .ready_i(ready_i), .resultado_o(resultado_o),
        .zero_o(zero_o), .carry_o(carry_o), .overflow_o(overflow_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: outputs follow from the opcode's arithmetic meaning.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic inv);
        exp_t m;
        int sa, sb, s, sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[2:0]);
        m.res = '0; m.c = 1'b0; m.v = 1'b0; m.e = 1'b0; m.lat = 1;
        case (op)
            4'b0000: m.res = a & b;
            4'b0001: m.res = a | b;
            4'b0100: m.res = a ^ b;
            4'b0010: begin
                if (inv) begin
                    m.res = a - b; m.c = (a >= b); s = sa - sb;
                end else begin
                    m.res = a + b; m.c = (int'(a) + int'(b)) > 255; s = sa + sb;
                end
                m.v = (s > 127) || (s < -128);
            end
            4'b0011: m.res = (sa < sb) ? 8'd1 : 8'd0;
            4'b0101: m.res = (a < b) ? 8'd1 : 8'd0;
            4'b0111: begin m.res = a >> sh; m.lat = 1 + sh; end
            4'b1000: begin m.res = a << sh; m.lat = 1 + sh; end
            4'b1001: begin m.res = $signed(a) >>> sh; m.lat = 1 + sh; end
            default: m.e = 1'b1;
        endcase
        m.z = (m.res == '0);
        return m;
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && valid_o) begin
                if (!exp_armed) begin
                    chk("unexpected_valid", valid_o, 1'b0);
                end else begin
                    chk("mon_res", resultado_o, exp_cur.res);
                    chk("mon_zero", zero_o, exp_cur.z);
                    chk("mon_carry", carry_o, exp_cur.c);
                    chk("mon_ovf", overflow_o, exp_cur.v);
                    chk("mon_err", err_o, exp_cur.e);
                    chk("mon_ready_busy", ready_o, 1'b0);
                end
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic inv, input logic [W-1:0] lit_res, input int lit_lat,
                          input int hold);
        exp_t m;
        int   lat;
        logic seen;
        m = model(op, a, b, inv);
        chk("model_pin", m.res, lit_res);
        @(negedge clk_i);
        chk("ready_idle", ready_o, 1'b1);
        a_i = a; b_i = b; invert_i = inv; operacion_i = op;
        valid_i = 1'b1;
        ready_i = (hold == 0);
        exp_cur = m;
        exp_armed = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        invert_i = ~inv; operacion_i = 4'($urandom);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk_i);
            lat++;
            if (valid_o) seen = 1'b1;
        end
        chk("valid_seen", seen, 1'b1);
        chk("latency", lat, lit_lat);
        chk("lit_res", resultado_o, lit_res);
        repeat (hold) begin
            valid_i = 1'b1;
            a_i = W'($urandom); operacion_i = 4'b0001;
            @(negedge clk_i);
            chk("hold_valid", valid_o, 1'b1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i);
        exp_armed = 1'b0;
        @(negedge clk_i);
        chk("release_ready", ready_o, 1'b1);
        chk("release_valid", valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_res", resultado_o, 0);
        chk("rst_flags", {zero_o, carry_o, overflow_o, err_o}, 0);

        run_op(4'b0010, 8'h7F, 8'h01, 1'b0, 8'h80, 1, 0);
        run_op(4'b0010, 8'h05, 8'h05, 1'b1, 8'h00, 1, 0);
        run_op(4'b0000, 8'hF0, 8'h3C, 1'b1, 8'h30, 1, 0);
        run_op(4'b0011, 8'hFF, 8'h01, 1'b0, 8'h01, 1, 0);
        run_op(4'b0101, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0);
        run_op(4'b1001, 8'h90, 8'h03, 1'b0, 8'hF2, 4, 0);
        run_op(4'b0111, 8'h90, 8'h03, 1'b0, 8'h12, 4, 0);
        run_op(4'b1000, 8'h90, 8'h03, 1'b0, 8'h80, 4, 0);
        run_op(4'b0111, 8'h90, 8'h00, 1'b0, 8'h90, 1, 0);
        run_op(4'b1001, 8'h81, 8'h07, 1'b0, 8'hFF, 8, 0);
        run_op(4'b0001, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1, 0);
        run_op(4'b0100, 8'hAA, 8'hFF, 1'b1, 8'h55, 1, 0);
        run_op(4'b0010, 8'h80, 8'h01, 1'b1, 8'h7F, 1, 0);
        run_op(4'b0010, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 3);
        run_op(4'b0110, 8'h12, 8'h34, 1'b0, 8'h00, 1, 0);
        run_op(4'b1111, 8'h56, 8'h78, 1'b0, 8'h00, 1, 0);

        // Explicit literal pins on flags of the first vectors' kind.
        exp_cur = model(4'b0010, 8'h7F, 8'h01, 1'b0);
        chk("pin_add_ovf", {exp_cur.v, exp_cur.c, exp_cur.z}, 3'b100);
        exp_cur = model(4'b0010, 8'h05, 8'h05, 1'b1);
        chk("pin_sub_flags", {exp_cur.v, exp_cur.c, exp_cur.z}, 3'b011);
        exp_cur = model(4'b0110, 8'h00, 8'h00, 1'b0);
        chk("pin_illegal", {exp_cur.e, exp_cur.z}, 2'b11);

        // Reset in the middle of a long SRL: the op must vanish.
        @(negedge clk_i);
        exp_armed = 1'b0;
        a_i = 8'h90; b_i = 8'h07; operacion_i = 4'b0111; invert_i = 1'b0;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("mid_shift_busy", ready_o, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mrst_valid", valid_o, 1'b0);
        chk("mrst_ready", ready_o, 1'b1);
        chk("mrst_res", resultado_o, 0);
        chk("mrst_flags", {zero_o, carry_o, overflow_o, err_o}, 0);
        repeat (10) @(negedge clk_i);
        chk("mrst_quiet", valid_o, 1'b0);

        run_op(4'b0010, 8'h10, 8'h20, 1'b0, 8'h30, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
Parametrised N-bit ALU that generalises the existing 1-bit ALU slice to a full word. It keeps the slice's opcode map and adds the unsigned-compare and shift operations, which are executed iteratively over several cycles. Operands are captured with a valid/ready handshake, and results are returned with flags through a held valid/ready output. It sits between the register-file read stage and writeback in the single-cycle/monocycle datapath, where a stall signal is derived from ready_o.

Parameters:
WIDTH, 32, datapath width in bits (≥4, power of two)
SHAMT_W, $clog2(WIDTH), shift-amount width (localparam, derived)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  operands/opcode valid
ready_o  out  1  block can accept an operation
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B; for shifts, b_i[SHAMT_W-1:0] is the shift amount
invert_i  in  1  ADD/SUB only: 1 = subtract (B inverted, carry-in 1)
operacion_i  in  4  opcode
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
resultado_o  out  WIDTH  result
zero_o  out  1  resultado_o == 0
carry_o  out  1  adder carry-out (ADD/SUB only, else 0)
overflow_o  out  1  signed overflow (ADD/SUB only, else 0)
err_o  out  1  illegal opcode flag, valid with valid_o

Behaviour:
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD/SUB
  - 0011 SLT (signed)
  - 0100 XOR
  - 0101 SLTU
  - 0111 SRL
  - 1000 SLL
  - 1001 SRA
  - Any other opcode is illegal.
- AND/OR/XOR use B (not inverted); invert_i is ignored for every opcode except 0010.
- SLT/SLTU always compute A + ~B + 1 internally.
  - SLT = sum[MSB] ^ overflow.
  - SLTU = ~carry.
  - Result is zero-extended to WIDTH in bit 0.
- Accept: transfer when valid_i && ready_o. a_i, b_i, opcode and invert_i are registered; later input changes have no effect.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: ready_o=1. On accept of a non-shift op → DONE with result computed. On accept of a shift op: if shamt==0 → DONE with result=A; else load working reg=A, counter=shamt, go to SHIFT.
  - SHIFT: shift the working reg one bit per cycle (SRL fills 0, SLL fills 0, SRA fills the sign bit) and decrement the counter. Leave for DONE on the cycle the counter reaches 0.
  - DONE: valid_o=1, ready_o=0. Outputs stay stable until ready_i=1, then → IDLE.
- Latency (accept edge to valid_o high): 1 cycle for non-shift ops and shamt 0; 1+shamt cycles for shifts. Max throughput is one op per 2 cycles.
- Illegal opcode: resultado_o=0, zero_o=1, err_o=1, 1-cycle latency.
- Flags are registered together with resultado_o. carry_o and overflow_o are 0 for non-ADD/SUB ops.
- Output valid_i while ready_o=0 is ignored (not queued).
- Reset (any state, including mid-shift): FSM=IDLE, ready_o=1 from the cycle after reset deasserts. valid_o, resultado_o, all flags and err_o are 0. Any in-flight op is dropped.
- Widths: the adder is WIDTH+1 bits internally; carry is the MSB. Overflow = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is B after inversion.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_AND…OP_SRA)
  - FSM state encoding
  - an is_shift() function
- One sub-module, alu_nbit_comb: the purely combinational single-cycle datapath (logic ops, adder, SLT/SLTU, flags), parametrised by WIDTH.
- The FSM, shift register and counter stay in alu_nbit_seq.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01, invert_i=0 → resultado_o=0x80, overflow_o=1, carry_o=0, zero_o=0; valid_o 1 cycle after accept.
- SUB 0x05−0x05 (0010, invert_i=1) → 0x00, zero_o=1, carry_o=1, overflow_o=0. AND 0xF0&0x3C → 0x30 with invert_i=1 (ignored).
- SLT a=0xFF, b=0x01 → 0x01; SLTU with the same operands → 0x00; err_o=0 for both.
- a=0x90, b=0x03: SRA → 0xF2, SRL → 0x12, SLL → 0x80, each with valid_o 4 cycles after accept. Shift with b=0x00 → 0x90 after 1 cycle.
- Backpressure: ADD result with ready_i=0 for 3 cycles → valid_o and outputs held constant, ready_o=0, valid_i pulses ignored. ready_i=1 → ready_o=1 the next cycle.
- Reset mid-SRL (b=7) on cycle 3 → next cycle valid_o=0, ready_o=1, resultado_o=0. Opcode 0110 → resultado_o=0, err_o=1, zero_o=1.
